// File: rtl/unidade_controle.sv
// Microcode-style control unit: sequences LOAD/STORE/ALU/NOP instructions into
// register-bank bus selects, write strobes and RAM commands via a Moore FSM.
module unidade_controle (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] instr,
  output logic [3:0] bbus_sig,
  output logic [9:0] cbus_sig,
  output logic [3:0] ram_addr,
  output logic [1:0] ram_wr_enable,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] instr_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_MAR, S_WAIT, S_MDR, S_SEL, S_HLD,
    S_SEL2, S_WB, S_WR, S_CLR, S_DONE, S_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [3:0] bbus_q, bbus_d;
  logic [9:0] cbus_q, cbus_d;
  logic [3:0] addr_q, addr_d;
  logic [1:0] rw_q, rw_d;
  logic [2:0] alu_q, alu_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  logic [3:0] opcode, operand;
  logic       reg_ok, is_alu;

  assign opcode  = instr_d[7:4];
  assign operand = instr_d[3:0];
  assign is_alu  = (opcode == 4'd3) || (opcode == 4'd4) || (opcode == 4'd5);
  assign reg_ok  = (operand == 4'd1) || ((operand >= 4'd4) && (operand <= 4'd8));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE:   if (start) begin
                  instr_d = instr;
                  state_d = S_DECODE;
                end
      S_DECODE: begin
                  if (opcode == 4'd0)                         state_d = S_DONE;
                  else if ((opcode == 4'd1) || (opcode == 4'd2)) state_d = S_MAR;
                  else if (is_alu && reg_ok)                  state_d = S_SEL;
                  else                                        state_d = S_ERR;
                end
      S_MAR:    state_d = (opcode == 4'd1) ? S_WAIT : S_SEL;
      S_WAIT:   state_d = S_MDR;
      S_MDR:    state_d = S_SEL;
      S_SEL:    state_d = is_alu ? S_HLD : S_WB;
      S_HLD:    state_d = S_SEL2;
      S_SEL2:   state_d = S_WB;
      S_WB:     state_d = (opcode == 4'd2) ? S_WR : S_DONE;
      S_WR:     state_d = S_CLR;
      S_CLR:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each register holds the
  // values belonging to the state it is entering.
  always_comb begin
    bbus_d = '0;
    cbus_d = '0;
    rw_d   = '0;
    alu_d  = '0;
    addr_d = addr_q;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) || (state_d == S_ERR);
    cnt_d  = cnt_q + 8'((state_d == S_DONE) ? 1 : 0);
    err_d  = err_q;
    if ((state_q == S_IDLE) && start) err_d = 1'b0;
    if (state_d == S_ERR)             err_d = 1'b1;
    case (state_d)
      S_MAR: begin
        addr_d    = operand;
        cbus_d[0] = 1'b1;
        if (opcode == 4'd1) begin
          cbus_d[2] = 1'b1;
          rw_d      = 2'b01;
        end
      end
      S_MDR:  cbus_d[1] = 1'b1;
      S_SEL:  bbus_d = (opcode == 4'd1) ? 4'd1 : 4'd7;
      S_HLD: begin
        bbus_d    = 4'd7;
        cbus_d[9] = 1'b1;
      end
      S_SEL2: bbus_d = operand;
      S_WB: begin
        case (opcode)
          4'd1: begin bbus_d = 4'd1; cbus_d[7] = 1'b1; end
          4'd2: begin bbus_d = 4'd7; cbus_d[3] = 1'b1; end
          4'd3: begin bbus_d = operand; cbus_d[7] = 1'b1; alu_d = 3'b001; end
          4'd4: begin bbus_d = operand; cbus_d[7] = 1'b1; alu_d = 3'b010; end
          4'd5: begin bbus_d = operand; cbus_d[7] = 1'b1; alu_d = 3'b011; end
          default: ;
        endcase
      end
      S_WR: begin
        cbus_d[2] = 1'b1;
        rw_d      = 2'b10;
      end
      S_CLR:  cbus_d[2] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      bbus_q  <= '0;
      cbus_q  <= '0;
      addr_q  <= '0;
      rw_q    <= '0;
      alu_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      bbus_q  <= bbus_d;
      cbus_q  <= cbus_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      alu_q   <= alu_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bbus_sig      = bbus_q;
  assign cbus_sig      = cbus_q;
  assign ram_addr      = addr_q;
  assign ram_wr_enable = rw_q;
  assign alu_op        = alu_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: per-cycle expected output snapshots
// are queued when an instruction is issued and compared after each clock edge.
module tb_unidade_controle;

  logic       clock, reset_n, start;
  logic [7:0] instr;
  logic [3:0] bbus_sig;
  logic [9:0] cbus_sig;
  logic [3:0] ram_addr;
  logic [1:0] ram_wr_enable;
  logic [2:0] alu_op;
  logic       busy, done, error;
  logic [7:0] instr_count;

  unidade_controle dut (
    .clock(clock), .reset_n(reset_n), .start(start), .instr(instr),
    .bbus_sig(bbus_sig), .cbus_sig(cbus_sig), .ram_addr(ram_addr),
    .ram_wr_enable(ram_wr_enable), .alu_op(alu_op), .busy(busy),
    .done(done), .error(error), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // snapshot layout: {bbus, cbus, addr, rw, alu, busy, done, error, count}
  typedef struct {
    string       tag;
    logic [33:0] v;
  } exp_t;

  exp_t       q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] m_addr   = '0;
  logic [7:0] m_cnt    = '0;
  logic       m_err    = 1'b0;

  function automatic logic [33:0] observed();
    return {bbus_sig, cbus_sig, ram_addr, ram_wr_enable, alu_op, busy, done, error, instr_count};
  endfunction

  task automatic p(input string tag, input logic [3:0] bb, input logic [9:0] cb,
                   input logic [1:0] rw, input logic [2:0] alu, input logic bsy, input logic dn);
    exp_t e;
    e.tag = tag;
    e.v   = {bb, cb, m_addr, rw, alu, bsy, dn, m_err, m_cnt};
    q.push_back(e);
  endtask

  task automatic compare(input string tag, input logic [33:0] exp_v);
    logic [33:0] obs;
    obs = observed();
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty observed=empty expected=entry");
      end else begin
        e = q.pop_front();
        compare(e.tag, e.v);
      end
    end
  endtask

  // Expected per-cycle trace, starting with the DECODE cycle and ending with
  // the IDLE cycle that follows DONE/ERR.
  task automatic push_instr(input logic [7:0] ins, input string t);
    logic [3:0] op, r;
    logic       rok;
    op  = ins[7:4];
    r   = ins[3:0];
    rok = (r == 4'd1) || (r == 4'd4) || (r == 4'd5) || (r == 4'd6) || (r == 4'd7) || (r == 4'd8);
    m_err = 1'b0;
    p({t, "_decode"}, 4'd0, 10'h000, 2'b00, 3'b000, 1'b1, 1'b0);
    if (op == 4'd1) begin
      m_addr = r;
      p({t, "_mar"},  4'd0, 10'h005, 2'b01, 3'b000, 1'b1, 1'b0);
      p({t, "_wait"}, 4'd0, 10'h000, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_mdr"},  4'd0, 10'h002, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_sel"},  4'd1, 10'h000, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_wb"},   4'd1, 10'h080, 2'b00, 3'b000, 1'b1, 1'b0);
    end else if (op == 4'd2) begin
      m_addr = r;
      p({t, "_mar"}, 4'd0, 10'h001, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_sel"}, 4'd7, 10'h000, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_wb"},  4'd7, 10'h008, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_wr"},  4'd0, 10'h004, 2'b10, 3'b000, 1'b1, 1'b0);
      p({t, "_clr"}, 4'd0, 10'h004, 2'b00, 3'b000, 1'b1, 1'b0);
    end else if ((op == 4'd3 || op == 4'd4 || op == 4'd5) && rok) begin
      p({t, "_sel"},  4'd7, 10'h000, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_hld"},  4'd7, 10'h200, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_sel2"}, r,    10'h000, 2'b00, 3'b000, 1'b1, 1'b0);
      p({t, "_wb"},   r,    10'h080, 2'b00,
        (op == 4'd3) ? 3'b001 : (op == 4'd4) ? 3'b010 : 3'b011, 1'b1, 1'b0);
    end
    if (op == 4'd0 || op == 4'd1 || op == 4'd2 || ((op == 4'd3 || op == 4'd4 || op == 4'd5) && rok)) begin
      m_cnt = m_cnt + 8'd1;
      p({t, "_done"}, 4'd0, 10'h000, 2'b00, 3'b000, 1'b1, 1'b1);
    end else begin
      m_err = 1'b1;
      p({t, "_err"}, 4'd0, 10'h000, 2'b00, 3'b000, 1'b1, 1'b1);
    end
    p({t, "_idle"}, 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [7:0] ins, input string t);
    @(negedge clock);
    start = 1'b1;
    instr = ins;
    push_instr(ins, t);
    check(1);
    start = 1'b0;
    check(q.size());
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    instr   = 8'h00;
    #12;
    compare("reset_state", 34'h0);
    @(negedge clock);
    reset_n = 1'b1;
    p("idle_after_reset", 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
    p("idle_after_reset", 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
    check(2);

    issue(8'h13, "load13");
    issue(8'h2A, "storeA");
    issue(8'h34, "add_sp");
    issue(8'h47, "sub_tos");
    issue(8'h51, "and_mdr");
    issue(8'h38, "add_opc");
    issue(8'h90, "illegal90");
    issue(8'h32, "illegal32");
    issue(8'h00, "nop_clr_err");
    issue(8'h50, "illegal50");
    issue(8'h16, "load6_clr_err");

    // start held high: the instruction changes mid-flight but only the value
    // present at the next IDLE visit is accepted
    @(negedge clock);
    start = 1'b1;
    instr = 8'h13;
    push_instr(8'h13, "held_load");
    push_instr(8'h47, "held_sub");
    check(3);
    instr = 8'h47;
    check(6);
    start = 1'b0;
    check(q.size());
    p("quiet_idle", 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
    p("quiet_idle", 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
    check(2);

    while (m_cnt != 8'hFF) issue(8'h00, "nop_fill");
    issue(8'h00, "nop_wrap");

    // reset pulsed while STORE sits in WR
    @(negedge clock);
    start = 1'b1;
    instr = 8'h2C;
    push_instr(8'h2C, "store_rst");
    check(1);
    start = 1'b0;
    check(4);
    q.delete();
    #2;
    reset_n = 1'b0;
    #1;
    compare("async_reset_in_wr", 34'h0);
    @(posedge clock);
    #1;
    compare("reset_held_edge", 34'h0);
    m_addr = '0;
    m_cnt  = '0;
    m_err  = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    p("idle_after_rst", 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
    p("idle_after_rst", 4'd0, 10'h000, 2'b00, 3'b000, 1'b0, 1'b0);
    check(2);
    issue(8'h00, "nop_after_rst");
    issue(8'h25, "store_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
